// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The slave side is the unit; the master side is the upstream/downstream pair.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [2:0]       op;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;
  logic [WIDTH-1:0] acc;

  modport slave (
    input  in_valid, x, y, op, acc_clr, out_ready,
    output in_ready, out_valid, result, zero, parity, acc
  );

  modport master (
    output in_valid, x, y, op, acc_clr, out_ready,
    input  in_ready, out_valid, result, zero, parity, acc
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with an in-order accumulator.
// S1 captures operands; S2 evaluates the op and registers result/zero/parity.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  logic_unit_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    OpAnd     = 3'b000,
    OpOr      = 3'b001,
    OpXor     = 3'b010,
    OpNor     = 3'b011,
    OpAndn    = 3'b100,
    OpAccOr   = 3'b101,
    OpAccXor  = 3'b110,
    OpAccLoad = 3'b111
  } op_e;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  op_e              s1_op_q, s1_op_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;

  // Accumulator
  logic [WIDTH-1:0] acc_q, acc_d;

  // Handshake
  logic             s1_load;
  logic             s2_load;
  logic             in_ready;

  // Datapath
  logic [WIDTH-1:0] op_res;
  logic             op_is_acc;

  assign s2_load  = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = bus.in_valid && in_ready;

  // The op sees acc_q as it stands before this edge, so back-to-back ACC ops chain in order.
  always_comb begin
    op_res    = '0;
    op_is_acc = 1'b0;
    unique case (s1_op_q)
      OpAnd:     op_res = s1_x_q & s1_y_q;
      OpOr:      op_res = s1_x_q | s1_y_q;
      OpXor:     op_res = s1_x_q ^ s1_y_q;
      OpNor:     op_res = ~(s1_x_q | s1_y_q);
      OpAndn:    op_res = s1_x_q & ~s1_y_q;
      OpAccOr: begin
        op_res    = acc_q | s1_y_q;
        op_is_acc = 1'b1;
      end
      OpAccXor: begin
        op_res    = acc_q ^ s1_y_q;
        op_is_acc = 1'b1;
      end
      OpAccLoad: begin
        op_res    = s1_x_q;
        op_is_acc = 1'b1;
      end
      default: begin
        op_res    = '0;
        op_is_acc = 1'b0;
      end
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_op_d    = s1_op_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_x_d     = bus.x;
      s1_y_d     = bus.y;
      s1_op_d    = op_e'(bus.op);
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Output registers only change on an S2 load, so they hold while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    parity_d   = parity_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      result_d   = op_res;
      zero_d     = (op_res == '0);
      parity_d   = ^op_res;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Clear wins over an ACC op landing on the same edge; that op's result still used the old acc.
  always_comb begin
    acc_d = acc_q;
    if (bus.acc_clr) begin
      acc_d = '0;
    end else if (s2_load && op_is_acc) begin
      acc_d = op_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_op_q    <= OpAnd;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_op_q    <= s1_op_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      parity_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      parity_q   <= parity_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed scenarios plus a randomized stream
// scored against an in-order reference model of the op table.
module tb_logic_unit_pipe;

  localparam int unsigned W = 16;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  logic_unit_pipe_if #(.WIDTH(W)) bus ();

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference semantics of one beat, executed in issue order.
  task automatic ref_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] acc_in, output logic [W-1:0] res,
                        output logic [W-1:0] acc_out);
    acc_out = acc_in;
    case (op)
      3'd0: res = x & y;
      3'd1: res = x | y;
      3'd2: res = x ^ y;
      3'd3: res = ~(x | y);
      3'd4: res = x & ~y;
      3'd5: begin res = acc_in | y; acc_out = res; end
      3'd6: begin res = acc_in ^ y; acc_out = res; end
      default: begin res = x; acc_out = x; end
    endcase
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.op        = 3'd0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.zero !== 1'b1 || bus.parity !== 1'b0 || bus.result !== '0) begin
      errors++;
      $display("FAIL reset_flags: got res=%h z=%b p=%b want 0000/1/0",
               bus.result, bus.zero, bus.parity);
    end
    vectors++;
    if (bus.acc !== '0) begin
      errors++; $display("FAIL reset_acc: got %h want 0000", bus.acc);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] want [5];
    want[0] = 16'h00F0; want[1] = 16'hFFF0; want[2] = 16'hFF00;
    want[3] = 16'h000F; want[4] = 16'hF000;
    pulse_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        vectors++;
        if (bus.out_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_latency: got out_valid=%b want 0", bus.out_valid);
        end
      end
      if (c >= 2) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.result !== want[c-2]) begin
          errors++;
          $display("FAIL b2b_op%0d: got v=%b res=%h want v=1 res=%h",
                   c - 2, bus.out_valid, bus.result, want[c-2]);
        end
      end
      if (c < 5) begin
        bus.in_valid = 1'b1; bus.x = 16'hF0F0; bus.y = 16'h0FF0; bus.op = 3'(c);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_acc_chain();
    logic [2:0]   ops  [3];
    logic [W-1:0] xs   [3];
    logic [W-1:0] ys   [3];
    logic [W-1:0] want [3];
    ops[0] = 3'd7; xs[0] = 16'h0001; ys[0] = 16'h0000; want[0] = 16'h0001;
    ops[1] = 3'd5; xs[1] = 16'h0000; ys[1] = 16'h0100; want[1] = 16'h0101;
    ops[2] = 3'd6; xs[2] = 16'h0000; ys[2] = 16'h0101; want[2] = 16'h0000;
    pulse_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.result !== want[c-2] ||
            bus.zero !== (want[c-2] == '0) || bus.acc !== want[c-2]) begin
          errors++;
          $display("FAIL acc_chain%0d: got v=%b res=%h z=%b acc=%h want res=acc=%h",
                   c - 2, bus.out_valid, bus.result, bus.zero, bus.acc, want[c-2]);
        end
      end
      if (c < 3) begin
        bus.in_valid = 1'b1; bus.x = xs[c]; bus.y = ys[c]; bus.op = ops[c];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] bx [4];
    logic [W-1:0] by [4];
    logic [2:0]   bo [4];
    logic [W-1:0] want [4];
    logic [W-1:0] got [$];
    logic [W-1:0] na;
    int sent;
    int taken_stalled;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      bx[i] = W'($urandom); by[i] = W'($urandom); bo[i] = 3'($urandom_range(4));
      ref_op(bo[i], bx[i], by[i], '0, want[i], na);
    end
    sent = 0;
    taken_stalled = 0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      @(negedge clk);
      bus.out_ready = (c >= 5);
      if (sent < 4) begin
        bus.in_valid = 1'b1; bus.x = bx[sent]; bus.y = by[sent]; bus.op = bo[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c >= 2 && c < 5) begin
        vectors++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, bus.in_ready);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        if (c < 5) taken_stalled++;
      end
      if (bus.out_valid && bus.out_ready) got.push_back(bus.result);
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (taken_stalled != 2) begin
      errors++; $display("FAIL bp_accepted_while_stalled: got %0d want 2", taken_stalled);
    end
    vectors++;
    if (got.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        errors++; $display("FAIL bp_beat%0d: got %h want %h", i, got[i], want[i]);
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_no_dup: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_acc_clr_collision();
    pulse_reset();
    bus.in_valid = 1'b1; bus.x = 16'h00FF; bus.y = '0; bus.op = 3'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.acc !== 16'h00FF) begin
      errors++; $display("FAIL clr_setup_acc: got %h want 00ff", bus.acc);
    end
    bus.in_valid = 1'b1; bus.x = '0; bus.y = 16'h0F00; bus.op = 3'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b1;
    @(negedge clk);
    bus.acc_clr  = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'h0FFF || bus.parity !== 1'b0 ||
        bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL clr_result: got v=%b res=%h p=%b z=%b want 1/0fff/0/0",
               bus.out_valid, bus.result, bus.parity, bus.zero);
    end
    vectors++;
    if (bus.acc !== '0) begin
      errors++; $display("FAIL clr_acc: got %h want 0000", bus.acc);
    end
  endtask

  task automatic test_reset_midflight();
    pulse_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.x = 16'hA5A5 + 16'(i); bus.y = '0; bus.op = 3'd7;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.acc !== 16'hA5A5) begin
      errors++;
      $display("FAIL mid_setup: got v=%b rdy=%b acc=%h want 1/0/a5a5",
               bus.out_valid, bus.in_ready, bus.acc);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.acc !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got v=%b acc=%h rdy=%b want 0/0000/1",
               bus.out_valid, bus.acc, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL mid_no_beat_c%0d: got out_valid=1 want 0", c);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q [$];
    logic [W-1:0] macc;
    logic [W-1:0] r;
    logic [W-1:0] na;
    logic [W-1:0] e;
    logic [W-1:0] held_r;
    logic         held_v;
    logic         took;
    pulse_reset();
    macc   = '0;
    held_v = 1'b0;
    held_r = '0;
    took   = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (held_v) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.result !== held_r) begin
          errors++;
          $display("FAIL rnd_hold_c%0d: got v=%b res=%h want 1/%h",
                   c, bus.out_valid, bus.result, held_r);
        end
      end
      if (took) bus.in_valid = 1'b0;
      if (!bus.in_valid && c < 450 && $urandom_range(3) != 0) begin
        bus.in_valid = 1'b1;
        bus.x  = W'($urandom);
        bus.y  = W'($urandom);
        bus.op = 3'($urandom_range(7));
      end
      bus.out_ready = (c >= 450) ? 1'b1 : ($urandom_range(3) != 0);
      #1;
      took = bus.in_valid && bus.in_ready;
      if (took) begin
        ref_op(bus.op, bus.x, bus.y, macc, r, na);
        exp_q.push_back(r);
        macc = na;
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_r = bus.result;
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_beat: got %h want none", bus.result);
        end else begin
          e = exp_q.pop_front();
          if (bus.result !== e || bus.zero !== (e == '0) || bus.parity !== ^e) begin
            errors++;
            $display("FAIL rnd_beat: got res=%h z=%b p=%b want res=%h z=%b p=%b",
                     bus.result, bus.zero, bus.parity, e, (e == '0), ^e);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rnd_lost: got %0d beats missing want 0", exp_q.size());
    end
    vectors++;
    if (bus.acc !== macc) begin
      errors++; $display("FAIL rnd_acc: got %h want %h", bus.acc, macc);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_acc_chain();
    test_backpressure();
    test_acc_clr_collision();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
